// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one edge-triggered FIFO write port.
// Each grant issues a 1-cycle write strobe followed by one gap cycle.
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                        fifo_full,
  output logic [N_REQ-1:0]            ack,
  output logic                        fifo_write_en,
  output logic [DATA_WIDTH-1:0]       fifo_data_in,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic                        busy,
  output logic [CNT_WIDTH-1:0]        write_count
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    GAP    = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [N_REQ-1:0]      ack_q, ack_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]         gid_q, gid_d;
  logic [IW-1:0]         last_q, last_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  grant;
  logic [IW-1:0]         win;

  // Scan farthest-first so the nearest set bit after last_q wins.
  always_comb begin
    grant = (req != '0) && !fifo_full;
    win   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(last_q) + k) % N_REQ]) begin
        win = IW'((int'(last_q) + k) % N_REQ);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      ack_q   <= '0;
      data_q  <= '0;
      gid_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = grant ? STROBE : IDLE;
      STROBE:  state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d   = 1'b0;
    ack_d  = '0;
    data_d = data_q;
    gid_d  = gid_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          we_d   = 1'b1;
          ack_d  = N_REQ'(1) << win;
          data_d = req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          gid_d  = win;
          last_d = win;
        end
      end
      STROBE:  cnt_d = cnt_q + CNT_WIDTH'(1);
      GAP:     ;
      default: ;
    endcase
  end

  assign fifo_write_en = we_q;
  assign ack           = ack_q;
  assign fifo_data_in  = data_q;
  assign grant_id      = gid_q;
  assign write_count   = cnt_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with a FIFO model
// and a narrow-counter instance for the wrap case.
module tb_fifo_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        fifo_full;
  logic [3:0]  ack;
  logic        fifo_write_en;
  logic [7:0]  fifo_data_in;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] write_count;

  logic [3:0]  w_ack;
  logic        w_we;
  logic [7:0]  w_data;
  logic [1:0]  w_gid;
  logic        w_busy;
  logic [3:0]  w_cnt;

  int errs = 0;
  int nchk = 0;
  int dbl  = 0;
  logic prev_we = 1'b0;
  logic [7:0] fq[$];

  always #5 clock = ~clock;

  fifo_write_arbiter #(
    .DATA_WIDTH(8), .N_REQ(4), .CNT_WIDTH(16)
  ) u_dut (
    .clock(clock), .reset(reset), .req(req),
    .req_data(req_data), .fifo_full(fifo_full),
    .ack(ack), .fifo_write_en(fifo_write_en),
    .fifo_data_in(fifo_data_in), .grant_id(grant_id),
    .busy(busy), .write_count(write_count)
  );

  fifo_write_arbiter #(
    .DATA_WIDTH(8), .N_REQ(4), .CNT_WIDTH(4)
  ) u_w4 (
    .clock(clock), .reset(reset), .req(req),
    .req_data(req_data), .fifo_full(fifo_full),
    .ack(w_ack), .fifo_write_en(w_we),
    .fifo_data_in(w_data), .grant_id(w_gid),
    .busy(w_busy), .write_count(w_cnt)
  );

  // FIFO model shares the reset; commits on the edge ending the strobe.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      fq.delete();
      prev_we = 1'b0;
    end else begin
      if (fifo_write_en) fq.push_back(fifo_data_in);
      if (fifo_write_en && prev_we) dbl++;
      prev_we = fifo_write_en;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    req   = '0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int bad;
    reset     = 1'b0;
    req       = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    #3;
    chk("rst_we",   32'(fifo_write_en), 0);
    chk("rst_ack",  32'(ack), 0);
    chk("rst_cnt",  32'(write_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gid",  32'(grant_id), 0);
    chk("rst_data", 32'(fifo_data_in), 0);
    tick();
    reset = 1'b1;

    // single request
    req_data[7:0] = 8'hA5;
    req = 4'b0001;
    tick();
    chk("s_we",   32'(fifo_write_en), 1);
    chk("s_ack",  32'(ack), 32'h1);
    chk("s_data", 32'(fifo_data_in), 32'hA5);
    chk("s_gid",  32'(grant_id), 0);
    chk("s_busy", 32'(busy), 1);
    req = 4'b0000;
    tick();
    chk("s_we0",  32'(fifo_write_en), 0);
    chk("s_ack0", 32'(ack), 0);
    chk("s_cnt",  32'(write_count), 1);
    chk("s_gap",  32'(busy), 1);
    tick();
    chk("s_idle", 32'(busy), 0);
    chk("s_fqn",  32'(fq.size()), 1);
    if (fq.size() > 0) chk("s_fq0", 32'(fq[0]), 32'hA5);

    // round robin from fresh reset
    do_reset();
    req_data = 32'h13121110;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_we",   32'(fifo_write_en), 1);
      chk("rr_gid",  32'(grant_id), 32'(i));
      chk("rr_ack",  32'(ack), 32'(1 << i));
      chk("rr_data", 32'(fifo_data_in), 32'(8'h10 + i));
      tick();
      chk("rr_gap1", 32'(fifo_write_en), 0);
      tick();
      chk("rr_gap2", 32'(fifo_write_en), 0);
      chk("rr_hold", 32'(fifo_data_in), 32'(8'h10 + i));
    end
    req = 4'b0000;
    chk("rr_cnt", 32'(write_count), 4);
    chk("rr_fqn", 32'(fq.size()), 4);
    for (int i = 0; i < 4 && i < fq.size(); i++)
      chk("rr_fq", 32'(fq[i]), 32'(8'h10 + i));

    // full stall
    fifo_full = 1'b1;
    req_data[23:16] = 8'h5C;
    req = 4'b0100;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fifo_write_en || ack != 0 || busy) bad++;
    end
    chk("st_quiet", 32'(bad), 0);
    chk("st_cnt",   32'(write_count), 4);
    fifo_full = 1'b0;
    tick();
    chk("st_we",   32'(fifo_write_en), 1);
    chk("st_gid",  32'(grant_id), 2);
    chk("st_ack",  32'(ack), 32'h4);
    chk("st_data", 32'(fifo_data_in), 32'h5C);
    req = 4'b0000;
    tick();
    tick();

    // fairness: after requester 3, requester 0 goes first
    req_data[31:24] = 8'h33;
    req = 4'b1000;
    tick();
    chk("f_gid3", 32'(grant_id), 3);
    req = 4'b0000;
    tick();
    tick();
    req_data[7:0] = 8'h40;
    req = 4'b1001;
    tick();
    chk("f_gid0",  32'(grant_id), 0);
    chk("f_data0", 32'(fifo_data_in), 32'h40);
    req = 4'b1000;
    tick();
    tick();
    tick();
    chk("f_gid3b", 32'(grant_id), 3);
    chk("f_data3", 32'(fifo_data_in), 32'h33);
    req = 4'b0000;
    tick();
    tick();
    chk("f_cnt", 32'(write_count), 8);

    // reset during strobe
    req = 4'b0010;
    tick();
    chk("r_we1", 32'(fifo_write_en), 1);
    #4;
    reset = 1'b0;
    #1;
    chk("r_we",   32'(fifo_write_en), 0);
    chk("r_ack",  32'(ack), 0);
    chk("r_cnt",  32'(write_count), 0);
    chk("r_busy", 32'(busy), 0);
    req = 4'b0000;
    tick();
    reset = 1'b1;
    chk("r_fqn", 32'(fq.size()), 0);
    req_data = 32'h53525150;
    req = 4'b1111;
    tick();
    chk("r_gid",  32'(grant_id), 0);
    chk("r_data", 32'(fifo_data_in), 32'h50);
    req = 4'b0000;
    tick();
    tick();

    // 17 writes: narrow counter wraps to 1
    do_reset();
    req_data[7:0] = 8'h77;
    req = 4'b0001;
    for (int i = 0; i < 49; i++) tick();
    req = 4'b0000;
    tick();
    tick();
    chk("w_cnt4",  32'(w_cnt), 1);
    chk("w_cnt16", 32'(write_count), 17);
    chk("w_fqn",   32'(fq.size()), 17);
    chk("no_b2b",  32'(dbl), 0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
